pipe_control: RTL and testbench

// Pipelined successor to the single-cycle MIPS control decoder. Decodes ISSUE_W opcodes per cycle in ID,

---
 rtl/pipe_ctrl_pkg.sv | 49 ++++
 rtl/ctrl_decode.sv | 35 +++
 rtl/pipe_control.sv | 185 ++++++++++++++++++
 tb/tb_pipe_control.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipelined control path.
// Contents:
//   - opcode constants for the supported instruction subset
//   - ALUop codes carried in the low three bits of the control bundle
//   - CTRL_W and the bit positions of each field inside a control bundle
//   - BUBBLE (all-zero bundle) and the fully decoded bundle per opcode
//   - touches_mem(): true when a bundle reads or writes data memory
// Bundle layout (bit 11 is reserved and always zero):
//   [10] RegDst [9] ALUSrc [8] MemtoReg [7] RegWrite [6] MemWrite
//   [5:4] Branch [3] ExtOp [2:0] ALUop
package pipe_ctrl_pkg;

  localparam int CTRL_W = 12;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_GTZ   = 3'b011;

  localparam int B_REGDST   = 10;
  localparam int B_MEMTOREG = 8;
  localparam int B_REGWRITE = 7;
  localparam int B_MEMWRITE = 6;
  localparam int B_BRANCH   = 4;

  localparam logic [CTRL_W-1:0] BUBBLE = 12'h000;

  // {rsvd, RegDst, ALUSrc, MemtoReg, RegWrite, MemWrite, Branch, ExtOp, ALUop}
  localparam logic [CTRL_W-1:0] CTRL_RTYPE = {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, ALU_FUNCT};
  localparam logic [CTRL_W-1:0] CTRL_ADDI  = {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, ALU_ADD};
  localparam logic [CTRL_W-1:0] CTRL_LW    = {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, ALU_ADD};
  localparam logic [CTRL_W-1:0] CTRL_SW    = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, ALU_ADD};
  localparam logic [CTRL_W-1:0] CTRL_BEQ   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, ALU_SUB};
  localparam logic [CTRL_W-1:0] CTRL_BNE   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, ALU_SUB};
  localparam logic [CTRL_W-1:0] CTRL_BGTZ  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1, ALU_GTZ};

  function automatic logic touches_mem(input logic [CTRL_W-1:0] c);
    return c[B_MEMTOREG] | c[B_MEMWRITE];
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Single-lane control decoder: opcode -> 12-bit control bundle.
// Ports:
//   valid    in   lane holds a real instruction
//   op       in   6-bit opcode
//   ctrl     out  control bundle (BUBBLE for invalid lane or unknown opcode)
//   reads_rt out  instruction uses rt as a source (R, sw, beq, bne)
module ctrl_decode
  import pipe_ctrl_pkg::*;
(
  input  logic              valid,
  input  logic [5:0]        op,
  output logic [CTRL_W-1:0] ctrl,
  output logic              reads_rt
);

  // Pure lookup; anything not recognised decays to a bubble so it can never
  // write state or trigger a hazard.
  always_comb begin
    ctrl     = BUBBLE;
    reads_rt = 1'b0;
    if (valid) begin
      case (op)
        OP_RTYPE: begin ctrl = CTRL_RTYPE; reads_rt = 1'b1; end
        OP_ADDI:  ctrl = CTRL_ADDI;
        OP_LW:    ctrl = CTRL_LW;
        OP_SW:    begin ctrl = CTRL_SW;    reads_rt = 1'b1; end
        OP_BEQ:   begin ctrl = CTRL_BEQ;   reads_rt = 1'b1; end
        OP_BNE:   begin ctrl = CTRL_BNE;   reads_rt = 1'b1; end
        OP_BGTZ:  ctrl = CTRL_BGTZ;
        default:  ctrl = BUBBLE;
      endcase
    end
  end

endmodule

// File: rtl/pipe_control.sv
// Pipelined control unit: decodes ISSUE_W lanes in ID, carries the control
// bundles through ID/EX, EX/MEM and MEM/WB, and resolves load-use and
// intra-bundle hazards for fetch.
// Parameters: ISSUE_W (1 or 2, lane 0 oldest), REG_AW (register specifier width)
// Ports:
//   clk, reset                 clock / synchronous active-high reset
//   id_valid, id_op            per-lane valid and opcode in ID
//   id_rs, id_rt, id_rd        per-lane register specifiers
//   flush                      taken branch: kill ID and EX
//   ext_stall                  freeze every pipeline register
//   ex_ctrl, mem_ctrl, wb_ctrl per-lane bundles in EX / MEM / WB
//   ex_dest                    per-lane EX destination (RegDst ? rd : rt)
//   stall                      load-use stall towards fetch
//   issue_cnt                  lanes accepted from ID this cycle
//   stall_count                stall-cycle counter
// Optional feature: define CTRL_STALL_CNT_EN to build the saturating stall
// counter; otherwise stall_count is tied to zero.
module pipe_control
  import pipe_ctrl_pkg::*;
#(
  parameter int ISSUE_W = 2,
  parameter int REG_AW  = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ISSUE_W-1:0]        id_valid,
  input  logic [6*ISSUE_W-1:0]      id_op,
  input  logic [REG_AW*ISSUE_W-1:0] id_rs,
  input  logic [REG_AW*ISSUE_W-1:0] id_rt,
  input  logic [REG_AW*ISSUE_W-1:0] id_rd,
  input  logic                      flush,
  input  logic                      ext_stall,
  output logic [CTRL_W*ISSUE_W-1:0] ex_ctrl,
  output logic [CTRL_W*ISSUE_W-1:0] mem_ctrl,
  output logic [CTRL_W*ISSUE_W-1:0] wb_ctrl,
  output logic [REG_AW*ISSUE_W-1:0] ex_dest,
  output logic                      stall,
  output logic [1:0]                issue_cnt,
  output logic [31:0]               stall_count
);

  logic [CTRL_W-1:0] dec_ctrl   [ISSUE_W];
  logic              dec_rt     [ISSUE_W];
  logic [REG_AW-1:0] rs         [ISSUE_W];
  logic [REG_AW-1:0] rt         [ISSUE_W];
  logic [REG_AW-1:0] id_dest    [ISSUE_W];
  logic              id_active  [ISSUE_W];

  logic [CTRL_W-1:0] issue_ctrl [ISSUE_W];
  logic [REG_AW-1:0] issue_dest [ISSUE_W];

  logic [CTRL_W-1:0] ex_ctrl_q  [ISSUE_W];
  logic [REG_AW-1:0] ex_dest_q  [ISSUE_W];
  logic [CTRL_W-1:0] mem_ctrl_q [ISSUE_W];
  logic [CTRL_W-1:0] wb_ctrl_q  [ISSUE_W];

  logic load_use;
  logic intra_hazard;

  for (genvar i = 0; i < ISSUE_W; i++) begin : g_lane
    ctrl_decode u_decode (
      .valid    (id_valid[i]),
      .op       (id_op[i*6 +: 6]),
      .ctrl     (dec_ctrl[i]),
      .reads_rt (dec_rt[i])
    );

    assign rs[i]        = id_rs[i*REG_AW +: REG_AW];
    assign rt[i]        = id_rt[i*REG_AW +: REG_AW];
    assign id_active[i] = (dec_ctrl[i] != BUBBLE);
    // Bubbles carry dest 0 so they can never match a consumer.
    assign id_dest[i]   = !id_active[i]        ? '0 :
                          dec_ctrl[i][B_REGDST] ? id_rd[i*REG_AW +: REG_AW] : rt[i];

    assign ex_ctrl [i*CTRL_W +: CTRL_W] = ex_ctrl_q[i];
    assign mem_ctrl[i*CTRL_W +: CTRL_W] = mem_ctrl_q[i];
    assign wb_ctrl [i*CTRL_W +: CTRL_W] = wb_ctrl_q[i];
    assign ex_dest [i*REG_AW +: REG_AW] = ex_dest_q[i];
  end

  // A load in EX whose (nonzero) destination is a source of any live ID lane.
  always_comb begin
    load_use = 1'b0;
    for (int e = 0; e < ISSUE_W; e++) begin
      for (int l = 0; l < ISSUE_W; l++) begin
        if (ex_ctrl_q[e][B_MEMTOREG] && ex_ctrl_q[e][B_REGWRITE] &&
            (ex_dest_q[e] != '0) && id_active[l] &&
            ((ex_dest_q[e] == rs[l]) || (dec_rt[l] && (ex_dest_q[e] == rt[l])))) begin
          load_use = 1'b1;
        end
      end
    end
  end

  // Pairing rules for a dual-issue bundle: lane 1 must not depend on lane 0,
  // only one memory op per bundle, and nothing rides behind a branch.
  if (ISSUE_W == 2) begin : g_dual
    logic raw;
    logic mem_pair;
    logic branch0;

    always_comb begin
      raw      = dec_ctrl[0][B_REGWRITE] && (id_dest[0] != '0) &&
                 ((id_dest[0] == rs[1]) || (dec_rt[1] && (id_dest[0] == rt[1])));
      mem_pair = touches_mem(dec_ctrl[0]) && touches_mem(dec_ctrl[1]);
      branch0  = (dec_ctrl[0][B_BRANCH +: 2] != 2'b00);
      intra_hazard = id_active[1] && (raw || mem_pair || branch0);
    end
  end else begin : g_single
    assign intra_hazard = 1'b0;
  end

  // What ID/EX would load on a normal advance.
  always_comb begin
    for (int i = 0; i < ISSUE_W; i++) begin
      issue_ctrl[i] = dec_ctrl[i];
      issue_dest[i] = id_dest[i];
      if (load_use || ((i == 1) && intra_hazard)) begin
        issue_ctrl[i] = BUBBLE;
        issue_dest[i] = '0;
      end
    end
  end

  // Fetch handshake; ext_stall and flush suppress both stall and issue.
  always_comb begin
    stall     = load_use && !ext_stall && !flush;
    issue_cnt = 2'd0;
    if (ext_stall || flush || load_use) begin
      issue_cnt = 2'd0;
    end else if (intra_hazard) begin
      issue_cnt = 2'd1;
    end else begin
      for (int i = 0; i < ISSUE_W; i++) begin
        issue_cnt = issue_cnt + {1'b0, id_valid[i]};
      end
    end
  end

  // Pipeline registers. A flush kills the two younger stages while the
  // branch itself (in MEM) still retires into WB.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ISSUE_W; i++) begin
      if (reset) begin
        ex_ctrl_q[i]  <= BUBBLE;
        ex_dest_q[i]  <= '0;
        mem_ctrl_q[i] <= BUBBLE;
        wb_ctrl_q[i]  <= BUBBLE;
      end else if (ext_stall) begin
        ex_ctrl_q[i]  <= ex_ctrl_q[i];
        ex_dest_q[i]  <= ex_dest_q[i];
        mem_ctrl_q[i] <= mem_ctrl_q[i];
        wb_ctrl_q[i]  <= wb_ctrl_q[i];
      end else if (flush) begin
        ex_ctrl_q[i]  <= BUBBLE;
        ex_dest_q[i]  <= '0;
        mem_ctrl_q[i] <= BUBBLE;
        wb_ctrl_q[i]  <= mem_ctrl_q[i];
      end else begin
        ex_ctrl_q[i]  <= issue_ctrl[i];
        ex_dest_q[i]  <= issue_dest[i];
        mem_ctrl_q[i] <= ex_ctrl_q[i];
        wb_ctrl_q[i]  <= mem_ctrl_q[i];
      end
    end
  end

`ifdef CTRL_STALL_CNT_EN
  logic [31:0] stall_count_q;

  // Counts every frozen cycle, from either cause, and sticks at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count_q <= '0;
    end else if ((stall || ext_stall) && (stall_count_q != 32'hFFFF_FFFF)) begin
      stall_count_q <= stall_count_q + 32'd1;
    end
  end

  assign stall_count = stall_count_q;
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_pipe_control.sv
// Directed self-checking bench for pipe_control (ISSUE_W=2, REG_AW=5).
// Expected bundles are hand-computed hex constants from the decode table.
module tb_pipe_control;

  localparam logic [11:0] C_R    = 12'h482;
  localparam logic [11:0] C_ADDI = 12'h288;
  localparam logic [11:0] C_LW   = 12'h388;
  localparam logic [11:0] C_SW   = 12'h248;
  localparam logic [11:0] C_BEQ  = 12'h019;
  localparam logic [11:0] C_BNE  = 12'h029;
  localparam logic [11:0] C_BGTZ = 12'h03B;

  localparam logic [5:0] O_R    = 6'b000000;
  localparam logic [5:0] O_ADDI = 6'b001000;
  localparam logic [5:0] O_LW   = 6'b100011;
  localparam logic [5:0] O_SW   = 6'b101011;
  localparam logic [5:0] O_BEQ  = 6'b000100;
  localparam logic [5:0] O_BNE  = 6'b000101;
  localparam logic [5:0] O_BGTZ = 6'b000111;

  logic        clk;
  logic        reset;
  logic [1:0]  id_valid;
  logic [11:0] id_op;
  logic [9:0]  id_rs;
  logic [9:0]  id_rt;
  logic [9:0]  id_rd;
  logic        flush;
  logic        ext_stall;
  logic [23:0] ex_ctrl;
  logic [23:0] mem_ctrl;
  logic [23:0] wb_ctrl;
  logic [9:0]  ex_dest;
  logic        stall;
  logic [1:0]  issue_cnt;
  logic [31:0] stall_count;

  int tests_run;
  int tests_failed;

  logic [5:0]  op_tab  [8] = '{O_R, O_ADDI, O_LW, O_SW, O_BEQ, O_BNE, O_BGTZ, 6'b111111};
  logic [11:0] exp_tab [8] = '{C_R, C_ADDI, C_LW, C_SW, C_BEQ, C_BNE, C_BGTZ, 12'h000};

  logic [5:0]  use_op  [3] = '{O_R, O_SW, O_BEQ};
  logic [4:0]  use_rs  [3] = '{5'd7, 5'd1, 5'd1};
  logic [4:0]  use_rt  [3] = '{5'd2, 5'd7, 5'd7};
  logic [11:0] use_exp [3] = '{C_R, C_SW, C_BEQ};

  pipe_control #(.ISSUE_W(2), .REG_AW(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .id_valid    (id_valid),
    .id_op       (id_op),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_rd       (id_rd),
    .flush       (flush),
    .ext_stall   (ext_stall),
    .ex_ctrl     (ex_ctrl),
    .mem_ctrl    (mem_ctrl),
    .wb_ctrl     (wb_ctrl),
    .ex_dest     (ex_dest),
    .stall       (stall),
    .issue_cnt   (issue_cnt),
    .stall_count (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearId();
    id_valid = 2'b00;
    id_op    = '0;
    id_rs    = '0;
    id_rt    = '0;
    id_rd    = '0;
  endtask

  task automatic applyStimulus(input int lane, input logic [5:0] op,
                               input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] rd);
    id_valid[lane]       = 1'b1;
    id_op[lane*6 +: 6]   = op;
    id_rs[lane*5 +: 5]   = rs;
    id_rt[lane*5 +: 5]   = rt;
    id_rd[lane*5 +: 5]   = rd;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    flush        = 1'b0;
    ext_stall    = 1'b0;
    reset        = 1'b1;
    clearId();
    applyStimulus(0, O_R, 5'd1, 5'd2, 5'd3);
    applyStimulus(1, O_LW, 5'd4, 5'd5, 5'd0);

    // Reset holds every stage at bubble regardless of ID contents.
    tick();
    tick();
    checkOutput("reset_ex",    ex_ctrl, 0);
    checkOutput("reset_mem",   mem_ctrl, 0);
    checkOutput("reset_wb",    wb_ctrl, 0);
    checkOutput("reset_stall", stall, 0);
    checkOutput("reset_cnt",   stall_count, 0);
    reset = 1'b0;

    // Every opcode in lane 0, with EX/MEM/WB latency checked along the way.
    for (int k = 0; k < 8; k++) begin
      clearId();
      applyStimulus(0, op_tab[k], 5'd1, 5'd0, 5'd3);
      #1;
      checkOutput("dec_issue_cnt", issue_cnt, 1);
      tick();
      checkOutput("dec_ex_lane0", ex_ctrl[11:0], exp_tab[k]);
      checkOutput("dec_ex_lane1", ex_ctrl[23:12], 0);
      if (k >= 1) checkOutput("lat_mem", mem_ctrl[11:0], exp_tab[k-1]);
      if (k >= 2) checkOutput("lat_wb",  wb_ctrl[11:0],  exp_tab[k-2]);
    end
    clearId();
    tick();
    tick();

    // Load-use: lw $8 then add rs=$8.
    applyStimulus(0, O_LW, 5'd1, 5'd8, 5'd0);
    tick();
    checkOutput("lu_ex_dest", ex_dest[4:0], 8);
    applyStimulus(0, O_R, 5'd8, 5'd2, 5'd4);
    #1;
    checkOutput("lu_stall",     stall, 1);
    checkOutput("lu_issue_cnt", issue_cnt, 0);
    tick();
    checkOutput("lu_ex_bubble", ex_ctrl[11:0], 0);
    checkOutput("lu_mem_lw",    mem_ctrl[11:0], C_LW);
    checkOutput("lu_released",  stall, 0);
    checkOutput("lu_reissue",   issue_cnt, 1);
    tick();
    checkOutput("lu_add_ex",    ex_ctrl[11:0], C_R);
    checkOutput("lu_add_dest",  ex_dest[4:0], 4);

    // Intra-bundle pairing rules.
    clearId();
    applyStimulus(0, O_R, 5'd1, 5'd2, 5'd9);
    applyStimulus(1, O_R, 5'd9, 5'd3, 5'd5);
    #1;
    checkOutput("ib_raw_cnt", issue_cnt, 1);
    tick();
    checkOutput("ib_raw_l0", ex_ctrl[11:0], C_R);
    checkOutput("ib_raw_l1", ex_ctrl[23:12], 0);
    clearId();
    applyStimulus(0, O_LW, 5'd1, 5'd11, 5'd0);
    applyStimulus(1, O_SW, 5'd2, 5'd12, 5'd0);
    #1;
    checkOutput("ib_mem_cnt", issue_cnt, 1);
    tick();
    checkOutput("ib_mem_l0", ex_ctrl[11:0], C_LW);
    checkOutput("ib_mem_l1", ex_ctrl[23:12], 0);
    clearId();
    applyStimulus(0, O_R, 5'd1, 5'd2, 5'd9);
    applyStimulus(1, O_R, 5'd3, 5'd4, 5'd10);
    #1;
    checkOutput("ib_pair_cnt", issue_cnt, 2);
    tick();
    checkOutput("ib_pair_l0",   ex_ctrl[11:0], C_R);
    checkOutput("ib_pair_l1",   ex_ctrl[23:12], C_R);
    checkOutput("ib_pair_dest", ex_dest[9:5], 10);
    clearId();
    applyStimulus(0, O_BEQ, 5'd1, 5'd2, 5'd0);
    applyStimulus(1, O_R, 5'd3, 5'd4, 5'd5);
    #1;
    checkOutput("ib_branch_cnt", issue_cnt, 1);

    // Flush with a load in EX; ID also hits that load, but flush outranks it.
    clearId();
    applyStimulus(0, O_R, 5'd1, 5'd2, 5'd3);
    tick();
    clearId();
    applyStimulus(0, O_LW, 5'd1, 5'd8, 5'd0);
    tick();
    checkOutput("fl_mem_before", mem_ctrl[11:0], C_R);
    clearId();
    applyStimulus(0, O_R, 5'd8, 5'd2, 5'd3);
    flush = 1'b1;
    #1;
    checkOutput("fl_stall", stall, 0);
    checkOutput("fl_cnt",   issue_cnt, 0);
    tick();
    flush = 1'b0;
    checkOutput("fl_ex",  ex_ctrl, 0);
    checkOutput("fl_mem", mem_ctrl, 0);
    checkOutput("fl_wb",  wb_ctrl[11:0], C_R);

    // Load to $0 never creates a hazard.
    clearId();
    applyStimulus(0, O_LW, 5'd1, 5'd0, 5'd0);
    tick();
    applyStimulus(0, O_R, 5'd0, 5'd0, 5'd3);
    #1;
    checkOutput("r0_stall", stall, 0);
    checkOutput("r0_cnt",   issue_cnt, 1);
    tick();
    checkOutput("r0_ex", ex_ctrl[11:0], C_R);

    // ext_stall for three cycles, the last one together with flush.
    clearId();
    applyStimulus(0, O_ADDI, 5'd1, 5'd5, 5'd0);
    tick();
    applyStimulus(0, O_SW, 5'd2, 5'd6, 5'd0);
    tick();
    applyStimulus(0, O_BEQ, 5'd1, 5'd2, 5'd0);
    ext_stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      flush = (c == 2);
      #1;
      checkOutput("es_stall", stall, 0);
      checkOutput("es_cnt",   issue_cnt, 0);
      tick();
      checkOutput("es_ex",  ex_ctrl[11:0],  C_SW);
      checkOutput("es_mem", mem_ctrl[11:0], C_ADDI);
      checkOutput("es_wb",  wb_ctrl[11:0],  C_R);
    end
    ext_stall = 1'b0;
    flush     = 1'b0;
    tick();
    checkOutput("es_resume_ex",  ex_ctrl[11:0],  C_BEQ);
    checkOutput("es_resume_mem", mem_ctrl[11:0], C_SW);
    checkOutput("es_resume_wb",  wb_ctrl[11:0],  C_ADDI);

    // Three more load-use stalls through rs and through rt.
    for (int j = 0; j < 3; j++) begin
      clearId();
      applyStimulus(0, O_LW, 5'd1, 5'd7, 5'd0);
      tick();
      applyStimulus(0, use_op[j], use_rs[j], use_rt[j], 5'd3);
      #1;
      checkOutput("lu2_stall", stall, 1);
      tick();
      checkOutput("lu2_bubble", ex_ctrl[11:0], 0);
      checkOutput("lu2_clear",  stall, 0);
      tick();
      checkOutput("lu2_issue", ex_ctrl[11:0], use_exp[j]);
    end

    // addi does not read rt, so lw $7 -> addi rt=$7 is not a hazard.
    clearId();
    applyStimulus(0, O_LW, 5'd1, 5'd7, 5'd0);
    tick();
    applyStimulus(0, O_ADDI, 5'd1, 5'd7, 5'd0);
    #1;
    checkOutput("addi_rt_nostall", stall, 0);
    clearId();
    tick();

`ifdef CTRL_STALL_CNT_EN
    // 4 load-use cycles + 3 ext_stall cycles.
    checkOutput("stall_count", stall_count, 7);
`else
    checkOutput("stall_count_off", stall_count, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
